// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Serialises the instruction-fetch (IF) and data-memory (DM) requesters of
//   the pipelined CPU onto one shared memory port using a req/ack handshake.
//   Completed results are held until the pipeline advances. MemStall tells
//   hazard detection to freeze the pipeline while an access in the current
//   pipeline cycle is still outstanding.
//
// Ports
//   clk, rst_n          clock (rising edge), synchronous active-low reset
//   if_req/if_addr      fetch request and address for this pipeline cycle
//   if_rdata/if_valid   fetched instruction, fetch complete this cycle
//   dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb
//                       load/store request for this pipeline cycle
//   dm_rdata/dm_valid   load data (0 for stores), data access complete
//   mem_req/mem_we/mem_addr/mem_wdata/mem_wstrb
//                       shared-port command, taken from the current owner
//   mem_rdata/mem_ack   shared-port read data and completion strobe
//   MemStall            pipeline stall request
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                MemStall
);

  typedef enum logic [1:0] {IDLE, LOCK_DM, LOCK_IF} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

  state_t              state, state_nxt;
  owner_t              owner;
  logic                if_done, dm_done;
  logic [DATA_W-1:0]   if_hold, dm_hold;
  logic                if_pend, dm_pend;
  logic                if_ack, dm_ack;

  assign if_pend = if_req & ~if_done;
  assign dm_pend = dm_req & ~dm_done;

  // Owner selection. Data wins in IDLE (older instruction); a LOCK state
  // pins the owner so the command cannot change mid-transaction. Reset
  // removes the owner, which withdraws mem_req immediately.
  always_comb begin
    owner = OWN_NONE;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (dm_pend)      owner = OWN_DM;
          else if (if_pend) owner = OWN_IF;
        end
        LOCK_DM: owner = OWN_DM;
        LOCK_IF: owner = OWN_IF;
        default: owner = OWN_NONE;
      endcase
    end
  end

  // Shared-port command from the owner, all zero when unowned.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    case (owner)
      OWN_IF: begin
        mem_req  = 1'b1;
        mem_addr = if_addr;
      end
      OWN_DM: begin
        mem_req   = 1'b1;
        mem_we    = dm_we;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
        mem_wstrb = dm_wstrb;
      end
      default: ;
    endcase
  end

  assign if_ack = (owner == OWN_IF) & mem_ack;
  assign dm_ack = (owner == OWN_DM) & mem_ack;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (!mem_ack) begin
          if (owner == OWN_DM)      state_nxt = LOCK_DM;
          else if (owner == OWN_IF) state_nxt = LOCK_IF;
        end
      end
      LOCK_DM, LOCK_IF: begin
        if (mem_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bypass the live response in the ack cycle, otherwise present the hold.
  assign if_valid = rst_n & (if_done | if_ack);
  assign dm_valid = rst_n & (dm_done | dm_ack);
  assign if_rdata = if_done ? if_hold : mem_rdata;
  assign dm_rdata = dm_we ? '0 : (dm_done ? dm_hold : mem_rdata);

  assign MemStall = rst_n & ((if_req & ~if_valid) | (dm_req & ~dm_valid));

  // An advancing edge discards results, including one acked on that same
  // edge for a requester that already dropped its request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      if_hold <= '0;
      dm_hold <= '0;
    end else begin
      state <= state_nxt;
      if (!MemStall) begin
        if_done <= 1'b0;
        dm_done <= 1'b0;
        if_hold <= '0;
        dm_hold <= '0;
      end else begin
        if (if_ack) begin
          if_done <= 1'b1;
          if_hold <= mem_rdata;
        end
        if (dm_ack) begin
          dm_done <= 1'b1;
          dm_hold <= dm_we ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed stimulus, a scoreboard of
// expected read data per requester, and one monitor process that performs
// every comparison at the falling clock edge.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req, if_valid;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we, dm_valid;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic [3:0]    dm_wstrb;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic [3:0]    mem_wstrb;
  logic          MemStall;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .MemStall(MemStall)
  );

  always #5 clk = ~clk;

  // Memory model: acks after wait_cfg cycles of a held request.
  int wait_cfg = 0;
  int wait_cnt = 0;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    case (a)
      32'h0000_0040: return 32'h0050_0093;
      32'h0000_0100: return 32'h1234_5678;
      32'h0000_0200: return 32'hCAFE_F00D;
      default:       return 32'hA5A5_0000 ^ a;
    endcase
  endfunction

  assign mem_ack   = mem_req && (wait_cnt >= wait_cfg);
  assign mem_rdata = mem_ack ? mem_word(mem_addr) : '0;

  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_cnt <= 0;
    else                     wait_cnt <= wait_cnt + 1;
  end

  // Scoreboard and per-cycle expectations (-1 = don't care).
  logic [DW-1:0] if_q[$];
  logic [DW-1:0] dm_q[$];
  int            e_req, e_stall, e_iv, e_dv;
  bit            e_chk_addr, e_chk_cmd;
  logic [AW-1:0] e_addr;
  logic [36:0]   e_cmd;
  string         e_tag = "init";
  bit            tb_done = 1'b0;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", e_tag, name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    int cyc;
    logic [DW-1:0] exp;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (e_req   >= 0) chk("mem_req",  {63'd0, mem_req},  e_req);
      if (e_stall >= 0) chk("MemStall", {63'd0, MemStall}, e_stall);
      if (e_iv    >= 0) chk("if_valid", {63'd0, if_valid}, e_iv);
      if (e_dv    >= 0) chk("dm_valid", {63'd0, dm_valid}, e_dv);
      if (e_chk_addr)   chk("mem_addr", {32'd0, mem_addr}, {32'd0, e_addr});
      if (e_chk_cmd)    chk("mem_cmd",  {27'd0, mem_we, mem_wstrb, mem_wdata}, {27'd0, e_cmd});
      if (rst_n && if_req && if_valid && !MemStall) begin
        if (if_q.size() == 0) chk("if_unexpected", 64'd1, 64'd0);
        else begin
          exp = if_q.pop_front();
          chk("if_rdata", {32'd0, if_rdata}, {32'd0, exp});
        end
      end
      if (rst_n && dm_req && dm_valid && !MemStall) begin
        if (dm_q.size() == 0) chk("dm_unexpected", 64'd1, 64'd0);
        else begin
          exp = dm_q.pop_front();
          chk("dm_rdata", {32'd0, dm_rdata}, {32'd0, exp});
        end
      end
      if (tb_done) begin
        chk("if_q_left", 64'(if_q.size()), 64'd0);
        chk("dm_q_left", 64'(dm_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
      if (cyc > 2000) begin
        chk("timeout", 64'd1, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  task automatic dc();
    e_req = -1; e_stall = -1; e_iv = -1; e_dv = -1;
    e_chk_addr = 1'b0; e_chk_cmd = 1'b0;
  endtask

  task automatic set_exp(input int req, input int stall, input int iv, input int dv,
                         input bit chk_addr, input logic [AW-1:0] addr);
    e_req = req; e_stall = stall; e_iv = iv; e_dv = dv;
    e_chk_addr = chk_addr; e_addr = addr; e_chk_cmd = 1'b0;
  endtask

  // One pipeline cycle: monitor samples at negedge, inputs change after posedge.
  task automatic cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
    dc();
  endtask

  task automatic drop_all();
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    dm_wdata = '0; dm_wstrb = '0;
  endtask

  initial begin : stim
    dc();
    rst_n = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    dm_wdata = '0; dm_wstrb = '0;

    // Reset with both requesting: nothing leaves the arbiter.
    e_tag = "reset";
    for (int i = 0; i < 2; i++) begin
      set_exp(0, 0, 0, 0, 1'b1, 32'h0);
      cycle();
    end

    // Release: DM first, then IF; one stall cycle.
    rst_n = 1'b1;
    e_tag = "both";
    dm_q.push_back(32'h1234_5678);
    if_q.push_back(32'h0050_0093);
    set_exp(1, 1, 0, 1, 1'b1, 32'h100);
    cycle();
    set_exp(1, 0, 1, 1, 1'b1, 32'h40);
    cycle();
    drop_all();
    e_tag = "both_clear";
    set_exp(0, 0, 0, 0, 1'b1, 32'h0);
    cycle();

    // Fetch only, zero-wait.
    e_tag = "if_only";
    if_req = 1'b1; if_addr = 32'h40;
    if_q.push_back(32'h0050_0093);
    set_exp(1, 0, 1, 0, 1'b1, 32'h40);
    cycle();
    drop_all();
    cycle();

    // Store with three wait states; command must stay stable.
    e_tag = "store";
    wait_cfg = 3;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h200;
    dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'b0011;
    dm_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      set_exp(1, (i < 3) ? 1 : 0, 0, (i == 3) ? 1 : 0, 1'b1, 32'h200);
      e_chk_cmd = 1'b1;
      e_cmd = {1'b1, 4'b0011, 32'hDEAD_BEEF};
      cycle();
    end
    drop_all();
    cycle();

    // Fetch locks the port; a late load waits for the fetch ack.
    e_tag = "lock";
    wait_cfg = 2;
    if_req = 1'b1; if_addr = 32'h80;
    if_q.push_back(32'hA5A5_0080);
    for (int c = 0; c < 6; c++) begin
      if (c == 1) begin
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
        dm_q.push_back(32'h1234_5678);
      end
      set_exp(1, (c < 5) ? 1 : 0, (c >= 2) ? 1 : 0, (c == 5) ? 1 : 0,
              1'b1, (c < 3) ? 32'h80 : 32'h100);
      cycle();
    end
    drop_all();
    cycle();

    // Reset during a locked load, then a fresh load.
    e_tag = "rst_lock";
    wait_cfg = 5;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h100;
    for (int c = 0; c < 2; c++) begin
      set_exp(1, 1, 0, 0, 1'b1, 32'h100);
      cycle();
    end
    rst_n = 1'b0;
    set_exp(0, 0, 0, 0, 1'b1, 32'h0);
    cycle();
    rst_n = 1'b1;
    dm_req = 1'b0;
    e_tag = "rst_after";
    set_exp(0, 0, 0, 0, 1'b1, 32'h0);
    cycle();
    e_tag = "reload";
    wait_cfg = 1;
    dm_req = 1'b1; dm_addr = 32'h200;
    dm_q.push_back(32'hCAFE_F00D);
    set_exp(1, 1, 0, 0, 1'b1, 32'h200);
    cycle();
    set_exp(1, 0, 0, 1, 1'b1, 32'h200);
    cycle();
    drop_all();
    cycle();

    tb_done = 1'b1;
  end

endmodule
